// File: rtl/div_pkg.sv
// Shared types for the iterative divider: FSM states and counter sizing.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } div_state_e;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_CNT_W = $clog2(DEF_WIDTH + 1);

    // Counter must hold the value WIDTH itself, hence WIDTH+1 codes.
    function automatic int unsigned cnt_bits(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in the next dividend
// bit and subtract the divisor when that does not borrow.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic [WIDTH:0]   picked;
    logic             unused_hi;

    // One guard bit above the WIDTH+1 trial exposes the borrow; the kept
    // remainder is always below the divisor, so its top bit is always zero.
    always_comb begin
        shifted   = {rem, dvd_msb};
        trial     = {1'b0, shifted} - {2'b00, divisor};
        q_bit     = ~trial[WIDTH+1];
        picked    = q_bit ? trial[WIDTH:0] : shifted;
        {unused_hi, rem_next} = picked;
    end

endmodule

// File: rtl/seq_divider.sv
// Radix-2 restoring divider with start/end handshake, signed/unsigned modes,
// divide-by-zero flag and flush cancel. Results hold until the next FIX.
module seq_divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             div_start,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] div_op1,
    input  logic [WIDTH-1:0] div_op2,
    input  logic             div_cancel,
    output logic             div_busy,
    output logic             div_end,
    output logic [WIDTH-1:0] div_result,
    output logic [WIDTH-1:0] div_remainder,
    output logic             div_by_zero
);

    localparam int unsigned CW = cnt_bits(WIDTH);

    div_state_e       state, state_nx;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rem_q, dvd_q, dsr_q, op1_q;
    logic             q_neg_q, r_neg_q, zero_q;
    logic [WIDTH-1:0] rem_nx;
    logic             q_bit;
    logic             accept;
    logic [WIDTH-1:0] op1_abs, op2_abs;

    assign accept  = (state == IDLE) && div_start && !div_cancel;
    assign op1_abs = (div_signed && div_op1[WIDTH-1]) ? -div_op1 : div_op1;
    assign op2_abs = (div_signed && div_op2[WIDTH-1]) ? -div_op2 : div_op2;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .dvd_msb  (dvd_q[WIDTH-1]),
        .divisor  (dsr_q),
        .rem_next (rem_nx),
        .q_bit    (q_bit)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = CALC;
            CALC: begin
                if (div_cancel)             state_nx = IDLE;
                else if (cnt_q == CW'(1))   state_nx = FIX;
            end
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q         <= '0;
            rem_q         <= '0;
            dvd_q         <= '0;
            dsr_q         <= '0;
            op1_q         <= '0;
            q_neg_q       <= 1'b0;
            r_neg_q       <= 1'b0;
            zero_q        <= 1'b0;
            div_busy      <= 1'b0;
            div_end       <= 1'b0;
            div_result    <= '0;
            div_remainder <= '0;
            div_by_zero   <= 1'b0;
        end else begin
            div_end <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt_q    <= CW'(WIDTH);
                        rem_q    <= '0;
                        dvd_q    <= op1_abs;
                        dsr_q    <= op2_abs;
                        op1_q    <= div_op1;
                        q_neg_q  <= div_signed && (div_op1[WIDTH-1] ^ div_op2[WIDTH-1]);
                        r_neg_q  <= div_signed && div_op1[WIDTH-1];
                        zero_q   <= (div_op2 == '0);
                        div_busy <= 1'b1;
                    end
                end
                CALC: begin
                    if (div_cancel) begin
                        div_busy <= 1'b0;
                    end else begin
                        rem_q <= rem_nx;
                        dvd_q <= {dvd_q[WIDTH-2:0], q_bit};
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                FIX: begin
                    div_busy <= 1'b0;
                    if (!div_cancel) begin
                        // Zero divisor overrides the (still fully run) datapath.
                        div_result    <= zero_q ? '1 : (q_neg_q ? -dvd_q : dvd_q);
                        div_remainder <= zero_q ? op1_q : (r_neg_q ? -rem_q : rem_q);
                        div_by_zero   <= zero_q;
                        div_end       <= 1'b1;
                    end
                end
                default: div_busy <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider at WIDTH=8 and WIDTH=32 against an
// arithmetic reference model.
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start8, start32, sgn, cancel;
    logic [31:0] op1, op2;

    logic        busy8, end8, dz8;
    logic [7:0]  res8, rem8;
    logic        busy32, end32, dz32;
    logic [31:0] res32, rem32;

    int tests = 0;
    int fails = 0;

    logic [31:0] prev_q [2];
    logic [31:0] prev_r [2];
    logic        prev_z [2];

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(8)) dut8 (
        .clk(clk), .resetn(resetn), .div_start(start8), .div_signed(sgn),
        .div_op1(op1[7:0]), .div_op2(op2[7:0]), .div_cancel(cancel),
        .div_busy(busy8), .div_end(end8), .div_result(res8),
        .div_remainder(rem8), .div_by_zero(dz8)
    );

    seq_divider #(.WIDTH(32)) dut32 (
        .clk(clk), .resetn(resetn), .div_start(start32), .div_signed(sgn),
        .div_op1(op1), .div_op2(op2), .div_cancel(cancel),
        .div_busy(busy32), .div_end(end32), .div_result(res32),
        .div_remainder(rem32), .div_by_zero(dz32)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wmask(input int w);
        return (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    endfunction

    function automatic longint sext(input logic [31:0] a, input int w);
        longint v;
        v = longint'(a & wmask(w));
        if (a[w-1]) v = v - (longint'(1) << w);
        return v;
    endfunction

    task automatic model(input int w, input logic s, input logic [31:0] a_in, input logic [31:0] b_in,
                         output logic [31:0] q, output logic [31:0] r, output logic z);
        logic [31:0] m, a, b;
        longint sa, sb;
        m = wmask(w);
        a = a_in & m;
        b = b_in & m;
        if (b == 0) begin
            q = m; r = a; z = 1'b1;
        end else if (s) begin
            sa = sext(a, w);
            sb = sext(b, w);
            q = 32'(sa / sb) & m;
            r = 32'(sa % sb) & m;
            z = 1'b0;
        end else begin
            q = a / b; r = a % b; z = 1'b0;
        end
    endtask

    task automatic sample(input int sel, output logic [31:0] q, output logic [31:0] r,
                          output logic z, output logic b, output logic e);
        if (sel == 0) begin
            q = {24'h0, res8}; r = {24'h0, rem8}; z = dz8; b = busy8; e = end8;
        end else begin
            q = res32; r = rem32; z = dz32; b = busy32; e = end32;
        end
    endtask

    function automatic logic [31:0] pick(input int w);
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1 << (w - 1);
            2:       return wmask(w);
            3:       return 32'($urandom_range(1, 9));
            default: return $urandom & wmask(w);
        endcase
    endfunction

    // Called at a negedge; returns at the negedge of the div_end cycle (or
    // after the bound), so a caller may start the next op back-to-back.
    task automatic run_op(input int sel, input logic s, input logic [31:0] a, input logic [31:0] b,
                          input bit inject, input bit do_rst, input int cancel_at);
        int w, lat;
        bit done;
        logic [31:0] eq, er, oq, orr;
        logic ez, oz, ob, oe;
        w = (sel == 1) ? 32 : 8;
        model(w, s, a, b, eq, er, ez);
        sgn = s; op1 = a; op2 = b;
        if (sel == 1) start32 = 1'b1; else start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0; start32 = 1'b0;
        op1 = $urandom; op2 = $urandom; sgn = 1'($urandom);
        lat = 0; done = 0;
        sample(sel, oq, orr, oz, ob, oe);
        check("busy_after_accept", 32'(ob), 32'd1);
        while (!done && lat < w + 8) begin
            if (lat == 3) begin
                check("held_result", oq, prev_q[sel]);
                check("held_remainder", orr, prev_r[sel]);
                check("busy_mid", 32'(ob), 32'd1);
            end
            if (inject && lat == 5) begin
                op1 = $urandom; op2 = $urandom;
                if (sel == 1) start32 = 1'b1; else start8 = 1'b1;
            end
            if (do_rst && lat == 7) begin
                resetn = 1'b0;
                #1;
                sample(sel, oq, orr, oz, ob, oe);
                check("rst_busy", 32'(ob), 32'd0);
                check("rst_end", 32'(oe), 32'd0);
                check("rst_result", oq, 32'd0);
                check("rst_remainder", orr, 32'd0);
                check("rst_dbz", 32'(oz), 32'd0);
                for (int i = 0; i < 2; i++) begin
                    prev_q[i] = '0; prev_r[i] = '0; prev_z[i] = 1'b0;
                end
                @(negedge clk);
                resetn = 1'b1;
                start8 = 1'b0; start32 = 1'b0;
                return;
            end
            if (lat == cancel_at) cancel = 1'b1;
            @(posedge clk);
            lat++;
            @(negedge clk);
            start8 = 1'b0; start32 = 1'b0; cancel = 1'b0;
            sample(sel, oq, orr, oz, ob, oe);
            if (oe) done = 1;
        end
        if (cancel_at >= 0) begin
            check("cancel_no_end", 32'(done), 32'd0);
            check("cancel_busy", 32'(ob), 32'd0);
            check("cancel_result", oq, prev_q[sel]);
            check("cancel_remainder", orr, prev_r[sel]);
            check("cancel_dbz", 32'(oz), 32'(prev_z[sel]));
        end else begin
            check("end_seen", 32'(done), 32'd1);
            check("latency", 32'(lat), 32'(w + 1));
            check("busy_at_end", 32'(ob), 32'd0);
            check("result", oq, eq);
            check("remainder", orr, er);
            check("dbz", 32'(oz), 32'(ez));
            prev_q[sel] = eq; prev_r[sel] = er; prev_z[sel] = ez;
        end
    endtask

    initial begin
        logic [31:0] q, r;
        logic z, b, e;
        resetn = 1'b0; start8 = 1'b0; start32 = 1'b0; cancel = 1'b0;
        sgn = 1'b0; op1 = '0; op2 = '0;
        for (int i = 0; i < 2; i++) begin
            prev_q[i] = '0; prev_r[i] = '0; prev_z[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int sel = 0; sel < 2; sel++) begin
            sample(sel, q, r, z, b, e);
            check("reset_result", q, 32'd0);
            check("reset_remainder", r, 32'd0);
            check("reset_dbz", 32'(z), 32'd0);
            check("reset_busy", 32'(b), 32'd0);
            check("reset_end", 32'(e), 32'd0);
        end
        resetn = 1'b1;
        @(negedge clk);

        run_op(1, 1'b0, 32'd100, 32'd7, 0, 0, -1);
        sample(1, q, r, z, b, e);
        check("u100_7_q", q, 32'd14);
        check("u100_7_r", r, 32'd2);
        @(negedge clk);
        run_op(1, 1'b1, -32'sd7, 32'd2, 0, 0, -1);
        check("s_m7_2_q", res32, 32'hFFFF_FFFD);
        check("s_m7_2_r", rem32, 32'hFFFF_FFFF);
        run_op(1, 1'b1, 32'd7, -32'sd2, 0, 0, -1);
        run_op(1, 1'b1, 32'h8000_0000, 32'd0, 0, 0, -1);
        check("dz_q", res32, 32'hFFFF_FFFF);
        check("dz_r", rem32, 32'h8000_0000);
        run_op(1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, -1);
        check("ovf_q", res32, 32'h8000_0000);
        check("ovf_r", rem32, 32'd0);
        run_op(1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, -1);
        run_op(0, 1'b1, 32'h80, 32'hFF, 0, 0, -1);
        run_op(0, 1'b1, 32'h85, 32'h00, 1, 0, -1);

        run_op(1, 1'b1, -32'sd1000, 32'd3, 0, 0, 10);
        run_op(1, 1'b0, 32'd9, 32'd3, 0, 0, -1);
        check("after_cancel_q", res32, 32'd3);
        check("after_cancel_r", rem32, 32'd0);

        for (int sel = 0; sel < 2; sel++) begin
            for (int n = 0; n < 40; n++) begin
                int w;
                logic [31:0] a, d;
                w = (sel == 1) ? 32 : 8;
                a = pick(w);
                d = pick(w);
                run_op(sel, 1'($urandom), a, d, ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 11) == 0), -1);
                if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
# seq_divider

Parametrised iterative radix-2 restoring divider for the CPU execute stage, serving DIV/DIVU with a start/end handshake. It supports signed and unsigned modes, applies the architectural sign correction to both quotient and remainder, flags divide-by-zero, and accepts a pipeline-flush cancel. Results are held stable until the next accepted start, so the HI/LO writeback logic can sample them late.

## Interface
- WIDTH, 32: operand and result width in bits, minimum 4.
- clk  in  1: single clock, rising edge.
- resetn  in  1: asynchronous, active-low reset.
- div_start  in  1: request; accepted only when div_busy=0.
- div_signed  in  1: 1 = signed (DIV), 0 = unsigned (DIVU); sampled with div_start.
- div_op1  in  WIDTH: dividend; sampled on acceptance.
- div_op2  in  WIDTH: divisor; sampled on acceptance.
- div_cancel  in  1: flush; aborts any operation in flight.
- div_busy  out  1: high from the cycle after acceptance until div_end.
- div_end  out  1: one-cycle pulse; results are valid from this cycle on.
- div_result  out  WIDTH: quotient.
- div_remainder  out  WIDTH: remainder.
- div_by_zero  out  1: set with div_end when op2 == 0; held with the results.

## Operation
- States: IDLE, CALC, FIX.
- IDLE + div_start + !div_cancel: latch the absolute values of the operands (signed mode only; unsigned mode passes them through), the quotient sign (op1[W-1]^op2[W-1] when signed), the remainder sign (op1[W-1] when signed), and the zero-divisor flag. Load count=WIDTH, partial remainder=0, then go to CALC.
- CALC, once per cycle: shift {rem, dividend} left by 1 and compute trial = rem - divisor on WIDTH+1 bits. If there is no borrow, rem=trial and the quotient bit is 1; otherwise the quotient bit is 0. Decrement count, and go to FIX when count reaches 1.
- FIX: negate the quotient if its sign flag is set, and negate the remainder if its sign flag is set. Register both to the outputs, pulse div_end, then go to IDLE.
- Divide by zero: the datapath runs unchanged (same latency). Forced outputs are div_result = all ones and div_remainder = op1 unmodified, with div_by_zero=1.
- Signed MIN / -1: no special case. Unsigned magnitude arithmetic yields quotient=MIN and remainder=0, with div_by_zero=0.
- div_start while busy is ignored and has no effect on the operation in flight.
- div_cancel in CALC or FIX: go to IDLE next cycle. No div_end is produced, and the outputs keep their previous values.
- div_cancel together with div_start in IDLE: cancel wins and nothing is accepted.
- Invariant for |a|/|b| with b≠0: |q|*|b| + |r| == |a| and |r| < |b|.

## Timing
- Reset values: div_busy=0, div_end=0, div_result=0, div_remainder=0, div_by_zero=0, state=IDLE.
- Start is accepted at edge E0. div_busy is high from E0 to E0+WIDTH+1. div_end is high for exactly the cycle after edge E0+WIDTH+1, and div_busy drops at that same edge.
- Fixed latency: WIDTH+1 cycles from acceptance to div_end, independent of operand values and of divide-by-zero.
- Back-to-back: div_start may be asserted during the div_end cycle (state is IDLE) and is accepted. The new operation leaves the held outputs unchanged until its own FIX cycle.
- resetn asserted mid-operation: immediate return to reset values, with no div_end.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package div_pkg: state enum (IDLE, CALC, FIX) and the count width localparam $clog2(WIDTH+1).
- Sub-module div_step: purely combinational single restoring iteration. Inputs are rem, the dividend MSB and the divisor; outputs are next rem and the quotient bit. It is instantiated once in the top.
- The top holds the FSM, counter, operand/sign registers and the output registers.

## Test plan
- Unsigned, WIDTH=32: 100 / 7 -> div_end exactly 33 cycles after acceptance; result 14, remainder 2, div_by_zero=0.
- Signed: -7 / 2 -> result -3 (0xFFFFFFFD), remainder -1. Signed 7 / -2 -> result -3, remainder 1.
- Divide by zero, signed, 0x80000000 / 0 -> result 0xFFFFFFFF, remainder 0x80000000, div_by_zero=1, same latency.
- Overflow case, signed 0x80000000 / 0xFFFFFFFF -> result 0x80000000, remainder 0. The same operands unsigned -> result 0, remainder 0x80000000.
- div_cancel at cycle 10 of CALC -> no div_end and outputs unchanged. Then div_start 9/3 on the next cycle -> result 3, remainder 0 at nominal latency.
- Random signed/unsigned stream at WIDTH=8 and WIDTH=32, with back-to-back starts in div_end cycles and random resetn pulses -> results match a reference model and satisfy the invariant. Starts issued while busy are ignored.
